// File: rtl/scrypt_pkg.sv
// Shared scrypt definitions: BlockMix controller state encoding, control word and decode.
package scrypt_pkg;

    localparam int unsigned STATE_W           = 4;
    localparam int unsigned DOUBLE_ROUNDS_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_X  = 4'd1,
        ST_XOR_0   = 4'd2,
        ST_ROUND_0 = 4'd3,
        ST_ADD_0   = 4'd4,
        ST_XOR_1   = 4'd5,
        ST_ROUND_1 = 4'd6,
        ST_ADD_1   = 4'd7,
        ST_DONE    = 4'd8
    } bm_state_e;

    typedef struct packed {
        logic valid;
        logic busy;
        logic load_x;
        logic xor_load;
        logic half_sel;
        logic round_en;
        logic feed_add;
        logic y_we;
    } bm_ctl_t;

    // Moore output decode: the datapath controls are a pure function of state.
    function automatic bm_ctl_t bm_decode(input bm_state_e st);
        bm_ctl_t c;
        c = '0;
        case (st)
            ST_LOAD_X: begin
                c.busy   = 1'b1;
                c.load_x = 1'b1;
            end
            ST_XOR_0, ST_XOR_1: begin
                c.busy     = 1'b1;
                c.xor_load = 1'b1;
                c.half_sel = (st == ST_XOR_1);
            end
            ST_ROUND_0, ST_ROUND_1: begin
                c.busy     = 1'b1;
                c.round_en = 1'b1;
                c.half_sel = (st == ST_ROUND_1);
            end
            ST_ADD_0, ST_ADD_1: begin
                c.busy     = 1'b1;
                c.feed_add = 1'b1;
                c.y_we     = 1'b1;
                c.half_sel = (st == ST_ADD_1);
            end
            ST_DONE: begin
                c.busy     = 1'b1;
                c.valid    = 1'b1;
                c.half_sel = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/blockmix_ct_counter.sv
// Salsa double-round counter with synchronous clear and terminal-count flag.
module salsa_round_counter #(
    parameter int unsigned MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Terminal count marks the last round cycle, so the FSM leaves ROUND after MAX_COUNT cycles.
    assign o_tc = (r_count == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/blockmix_ct.sv
// BlockMix (r = 1) control FSM: sequences load, XOR, Salsa rounds and feed-forward for both halves.
module blockmix_ct
    import scrypt_pkg::*;
#(
    parameter int unsigned DOUBLE_ROUNDS = DOUBLE_ROUNDS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic blockmix_en,
    output logic blockmix_valid,
    output logic busy,
    output logic load_x,
    output logic xor_load,
    output logic half_sel,
    output logic round_en,
    output logic feed_add,
    output logic y_we
);

    bm_state_e r_state;
    bm_state_e w_next;
    bm_ctl_t   r_ctl;
    logic      w_in_round;
    logic      w_cnt_clr;
    logic      w_tc;

    assign w_in_round = (r_state == ST_ROUND_0) || (r_state == ST_ROUND_1);
    // Count only while staying in a ROUND state; any entry or exit restarts from zero.
    assign w_cnt_clr  = !(w_in_round && (w_next == r_state));

    salsa_round_counter #(
        .MAX_COUNT (DOUBLE_ROUNDS)
    ) u_round_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .i_clr (w_cnt_clr),
        .i_en  (w_in_round),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_next = blockmix_en ? ST_LOAD_X : ST_IDLE;
            ST_LOAD_X:  w_next = ST_XOR_0;
            ST_XOR_0:   w_next = ST_ROUND_0;
            ST_ROUND_0: w_next = w_tc ? ST_ADD_0 : ST_ROUND_0;
            ST_ADD_0:   w_next = ST_XOR_1;
            ST_XOR_1:   w_next = ST_ROUND_1;
            ST_ROUND_1: w_next = w_tc ? ST_ADD_1 : ST_ROUND_1;
            ST_ADD_1:   w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        // Dropping the request aborts a run; DONE ignores en since the requester still holds it high.
        if (!blockmix_en && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            w_next = ST_IDLE;
        end
    end

    // Outputs are decoded from the next state so they are registered yet still Moore-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= bm_decode(w_next);
        end
    end

    assign blockmix_valid = r_ctl.valid;
    assign busy           = r_ctl.busy;
    assign load_x         = r_ctl.load_x;
    assign xor_load       = r_ctl.xor_load;
    assign half_sel       = r_ctl.half_sel;
    assign round_en       = r_ctl.round_en;
    assign feed_add       = r_ctl.feed_add;
    assign y_we           = r_ctl.y_we;

endmodule
